// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the multi-channel SPI DAC write controller.
package dac_spi_pkg;

  // Controller states; one frame walks IDLE -> SETUP -> SHIFT -> GAP [-> LDAC] -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } state_e;

  // LDAC update policies.
  localparam int LDAC_PER_FRAME   = 0;  // pulse after every frame
  localparam int LDAC_WHEN_IDLE   = 1;  // pulse once nothing is left pending
  localparam int LDAC_TRANSPARENT = 2;  // ldac_n held low permanently

  // Widest frame the helper can assemble; callers slice down to their own width.
  localparam int FRAME_MAX_W = 32;

  // Assemble {1'b0, ch, val}. The leading zero comes for free because the caller
  // keeps only 1+CH_W+VAL_W bits and ch never reaches 2**CH_W.
  function automatic logic [FRAME_MAX_W-1:0] build_frame(input logic [7:0]  ch,
                                                         input logic [23:0] val,
                                                         input int unsigned val_w);
    logic [FRAME_MAX_W-1:0] f;
    f = ({24'd0, ch} << val_w) | {8'd0, val};
    return f;
  endfunction

endpackage

// File: rtl/dac_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module dac_rr_pick
  import dac_spi_pkg::*;
#(
  parameter int CH_NUM = 8,
  parameter int CH_W   = 3
) (
  input  logic [CH_NUM-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_o
);

  logic [CH_W-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest set request wins last.
  always_comb begin
    grant_o = {CH_W{1'b0}};
    any_o   = 1'b0;
    idx_s   = {CH_W{1'b0}};
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      idx_s = CH_W'((int'(ptr_i) + i) % CH_NUM);
      if (req_i[idx_s]) begin
        grant_o = idx_s;
        any_o   = 1'b1;
      end else begin
        any_o   = any_o;
      end
    end
  end

endmodule

// File: rtl/dac_spi_mch_ctrl.sv
// Multi-channel SPI DAC write controller: per-channel shadow registers, dirty-bit
// round-robin service, MSB-first {0, ch, value} frames and LDAC strobe policy.
module dac_spi_mch_ctrl
  import dac_spi_pkg::*;
#(
  parameter int CH_NUM    = 8,
  parameter int CH_W      = 3,
  parameter int VAL_W     = 12,
  parameter int DIV_CNT   = 20,
  parameter int CS_SETUP  = 2,
  parameter int GAP       = 10,
  parameter int LDAC_W    = 5,
  parameter int LDAC_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [VAL_W-1:0]  wr_val,
  output logic              wr_err,
  output logic [CH_NUM-1:0] pending,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_n,
  output logic              sclk,
  output logic              dout,
  output logic              ldac_n
);

  localparam int DATA_W = 1 + CH_W + VAL_W;
  localparam int CNT_W  = 16;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_W - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] DIV_HALF   = CNT_W'(DIV_CNT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CH_NUM - 1);
  localparam logic             LDAC_IDLE  = (LDAC_MODE == LDAC_TRANSPARENT) ? 1'b0 : 1'b1;

  state_e             state_q;
  logic [DATA_W-1:0]  frame_q, frame_s;
  logic [VAL_W-1:0]   shadow_q [CH_NUM];
  logic [CH_NUM-1:0]  pending_q, pending_d, clr_s, set_s;
  logic [CH_W-1:0]    ptr_q, ptr_d, grant_s;
  logic               any_s, pick_s, wr_ok_s;
  logic [CNT_W-1:0]   cnt_q, div_q, div_inc_s;
  logic [BIT_W-1:0]   bit_q;
  logic               sync_n_q, sclk_q, dout_q, ldac_n_q, busy_q, frame_done_q, wr_err_q;

  dac_rr_pick #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_pick (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .any_o   (any_s)
  );

  assign wr_ok_s   = wr_en && (int'(wr_ch) < CH_NUM);
  assign pick_s    = (state_q == ST_IDLE) && any_s;
  // A same-cycle write to the picked channel re-arms it, so its new value gets its own frame.
  assign clr_s     = {{(CH_NUM-1){1'b0}}, pick_s}  << grant_s;
  assign set_s     = {{(CH_NUM-1){1'b0}}, wr_ok_s} << wr_ch;
  assign pending_d = (pending_q & ~clr_s) | set_s;
  assign ptr_d     = (grant_s == CH_LAST) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
  assign frame_s   = DATA_W'(build_frame(8'(grant_s), 24'(shadow_q[grant_s]), VAL_W));
  assign div_inc_s = div_q + CNT_W'(1);

  assign wr_err     = wr_err_q;
  assign pending    = pending_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sync_n     = sync_n_q;
  assign sclk       = sclk_q;
  assign dout       = dout_q;
  assign ldac_n     = ldac_n_q;

  // Shadow registers hold the latest accepted value for each channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) shadow_q[i] <= {VAL_W{1'b0}};
    end else if (wr_ok_s) begin
      shadow_q[wr_ch] <= wr_val;
    end
  end

  // Frame sequencer: picks a dirty channel, shifts its frame out, then handles LDAC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_q      <= {DATA_W{1'b0}};
      pending_q    <= {CH_NUM{1'b0}};
      ptr_q        <= {CH_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      div_q        <= {CNT_W{1'b0}};
      bit_q        <= {BIT_W{1'b0}};
      sync_n_q     <= 1'b1;
      sclk_q       <= 1'b1;
      dout_q       <= 1'b0;
      ldac_n_q     <= LDAC_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      wr_err_q     <= wr_en && !wr_ok_s;
      pending_q    <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (any_s) begin
            frame_q  <= frame_s;
            ptr_q    <= ptr_d;
            cnt_q    <= {CNT_W{1'b0}};
            sync_n_q <= 1'b0;
            sclk_q   <= 1'b1;
            dout_q   <= frame_s[DATA_W-1];
            busy_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            div_q   <= {CNT_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            sclk_q  <= 1'b1;
            dout_q  <= frame_q[DATA_W-1];
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (div_q == DIV_LAST) begin
            if (bit_q == BIT_LAST) begin
              sync_n_q     <= 1'b1;
              sclk_q       <= 1'b1;
              dout_q       <= 1'b0;
              frame_done_q <= 1'b1;
              cnt_q        <= {CNT_W{1'b0}};
              state_q      <= ST_GAP;
            end else begin
              // Next bit: shift the frame so the new MSB is the bit going out.
              div_q   <= {CNT_W{1'b0}};
              bit_q   <= bit_q + BIT_W'(1);
              sclk_q  <= 1'b1;
              dout_q  <= frame_q[DATA_W-2];
              frame_q <= {frame_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            div_q  <= div_inc_s;
            sclk_q <= (div_inc_s < DIV_HALF);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= {CNT_W{1'b0}};
            if ((LDAC_MODE == LDAC_PER_FRAME) ||
                ((LDAC_MODE == LDAC_WHEN_IDLE) && (pending_q == {CH_NUM{1'b0}}))) begin
              ldac_n_q <= 1'b0;
              state_q  <= ST_LDAC;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_LDAC: begin
          if (cnt_q == LDAC_LAST) begin
            ldac_n_q <= LDAC_IDLE;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          sync_n_q <= 1'b1;
          sclk_q   <= 1'b1;
          dout_q   <= 1'b0;
          ldac_n_q <= LDAC_IDLE;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_mch_ctrl.sv
// Bench for dac_spi_mch_ctrl: four instances (LDAC modes 0/1/2 with 8 channels, mode 1
// with 6 channels) share one write stream; SPI frames are decoded from the pins and
// compared with a write-list reference model of shadowing and round-robin order.
module tb_dac_spi_mch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_val;

  logic       sync_a [4], sclk_a [4], dout_a [4], ldac_a [4];
  logic       busy_a [4], fd_a [4], err_a [4];
  logic [7:0] pend_a [3];
  logic [5:0] pend6;

  always #5 clk = ~clk;

  dac_spi_mch_ctrl #(.CH_NUM(8), .LDAC_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
    .wr_err(err_a[0]), .pending(pend_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0]),
    .sync_n(sync_a[0]), .sclk(sclk_a[0]), .dout(dout_a[0]), .ldac_n(ldac_a[0]));
  dac_spi_mch_ctrl #(.CH_NUM(8), .LDAC_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
    .wr_err(err_a[1]), .pending(pend_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1]),
    .sync_n(sync_a[1]), .sclk(sclk_a[1]), .dout(dout_a[1]), .ldac_n(ldac_a[1]));
  dac_spi_mch_ctrl #(.CH_NUM(8), .LDAC_MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
    .wr_err(err_a[2]), .pending(pend_a[2]), .busy(busy_a[2]), .frame_done(fd_a[2]),
    .sync_n(sync_a[2]), .sclk(sclk_a[2]), .dout(dout_a[2]), .ldac_n(ldac_a[2]));
  dac_spi_mch_ctrl #(.CH_NUM(6), .LDAC_MODE(1)) u_c6 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
    .wr_err(err_a[3]), .pending(pend6), .busy(busy_a[3]), .frame_done(fd_a[3]),
    .sync_n(sync_a[3]), .sclk(sclk_a[3]), .dout(dout_a[3]), .ldac_n(ldac_a[3]));

  // ---------------- pin monitor (samples on the falling clk edge) ----------------
  logic [15:0] sh [4];
  logic [15:0] rx_fr [4][256];
  logic        psync [4], psclk [4], pldac [4];
  int nb [4], lo_len [4], ldac_len [4];
  int rx_n [4], bad_fr [4], pulses [4], bad_ldac [4], ldac_hi [4], fd_n [4], err_n [4], sync_lo [4];

  // Decode frames, measure sync_n/ldac_n low widths and count pulses per instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      psync[k] <= sync_a[k];
      psclk[k] <= sclk_a[k];
      pldac[k] <= ldac_a[k];
      if (!rst_n) begin
        sh[k] <= 16'h0000; nb[k] <= 0; lo_len[k] <= 0; ldac_len[k] <= 0;
      end else begin
        if (fd_a[k])  fd_n[k]    <= fd_n[k] + 1;
        if (err_a[k]) err_n[k]   <= err_n[k] + 1;
        if (ldac_a[k]) ldac_hi[k] <= ldac_hi[k] + 1;
        if (!sync_a[k]) begin
          lo_len[k]  <= lo_len[k] + 1;
          sync_lo[k] <= sync_lo[k] + 1;
        end
        if (psclk[k] && !sclk_a[k] && !sync_a[k]) begin
          sh[k] <= {sh[k][14:0], dout_a[k]};
          nb[k] <= nb[k] + 1;
        end
        if (!psync[k] && sync_a[k]) begin
          rx_fr[k][rx_n[k] % 256] <= sh[k];
          if (nb[k] != 16 || lo_len[k] != 322) bad_fr[k] <= bad_fr[k] + 1;
          rx_n[k]   <= rx_n[k] + 1;
          nb[k]     <= 0;
          lo_len[k] <= 0;
        end
        if (!ldac_a[k]) begin
          ldac_len[k] <= ldac_len[k] + 1;
        end else if (!pldac[k]) begin
          pulses[k] <= pulses[k] + 1;
          if (ldac_len[k] != 5) bad_ldac[k] <= bad_ldac[k] + 1;
          ldac_len[k] <= 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- burst stimulus and reference model ----------------
  int          b_n;
  int          b_ch [8];
  logic [11:0] b_val [8];
  int          b_gap [8];
  logic [15:0] exp_fr [16];
  int          exp_n, exp_inv;
  int b_rx [4], b_fd [4], b_pul [4], b_bf [4], b_bl [4], b_hi [4], b_err [4], b_lo [4];

  // Expected frames for one burst of writes that all land inside the first frame:
  // the first valid write is served at once with the value it carried; every channel
  // written afterwards (including a rewrite of that first one) is served once, with
  // its latest value, in round-robin order starting just after the first channel.
  task automatic model(input int chn);
    logic [11:0] shv [8];
    logic [7:0]  pnd;
    int          first, ptr, c;
    bit          found;
    pnd = 8'h00; first = -1; ptr = 0; c = 0; exp_n = 0; exp_inv = 0;
    for (int i = 0; i < 8; i++) shv[i] = 12'h000;
    for (int i = 0; i < b_n; i++) begin
      if (b_ch[i] >= chn) begin
        exp_inv++;
      end else begin
        shv[b_ch[i]] = b_val[i];
        if (first < 0) begin
          first = b_ch[i];
          c = first;
          exp_fr[0] = {1'b0, c[2:0], b_val[i]};
          exp_n = 1;
          ptr = (first + 1) % chn;
        end else begin
          pnd[b_ch[i]] = 1'b1;
        end
      end
    end
    while (pnd != 8'h00) begin
      found = 1'b0;
      for (int j = 0; j < chn; j++) begin
        c = (ptr + j) % chn;
        if (!found && pnd[c]) begin
          found = 1'b1;
          exp_fr[exp_n] = {1'b0, c[2:0], shv[c]};
          exp_n++;
          pnd[c] = 1'b0;
          ptr = (c + 1) % chn;
        end
      end
    end
  endtask

  task automatic snapshot();
    for (int k = 0; k < 4; k++) begin
      b_rx[k] = rx_n[k]; b_fd[k] = fd_n[k]; b_pul[k] = pulses[k]; b_bf[k] = bad_fr[k];
      b_bl[k] = bad_ldac[k]; b_hi[k] = ldac_hi[k]; b_err[k] = err_n[k]; b_lo[k] = sync_lo[k];
    end
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (pend6 == 6'h00) && !busy_a[3] && sync_a[3];
    for (int k = 0; k < 3; k++) q = q && (pend_a[k] == 8'h00) && !busy_a[k] && sync_a[k];
    return q;
  endfunction

  task automatic wait_idle(input string name);
    int cyc, quiet;
    cyc = 0; quiet = 0;
    while (quiet < 4 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (all_quiet()) quiet++; else quiet = 0;
    end
    if (quiet < 4) check_eq({name, " idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_burst(input string name);
    int exp_p;
    snapshot();
    for (int i = 0; i < b_n; i++) begin
      wr_en = 1'b1; wr_ch = 3'(b_ch[i]); wr_val = b_val[i];
      @(negedge clk);
      wr_en = 1'b0;
      if (b_ch[i] >= 6) check_eq({name, " u6_wr_err_pulse"}, 32'(err_a[3]), 32'd1);
      repeat (b_gap[i]) @(negedge clk);
    end
    wait_idle(name);
    for (int k = 0; k < 4; k++) begin
      model(k == 3 ? 6 : 8);
      check_eq($sformatf("%s u%0d frames", name, k), 32'(rx_n[k] - b_rx[k]), 32'(exp_n));
      for (int i = 0; i < exp_n && i < rx_n[k] - b_rx[k]; i++)
        check_eq($sformatf("%s u%0d frame%0d", name, k, i), 32'(rx_fr[k][(b_rx[k] + i) % 256]),
                 32'(exp_fr[i]));
      check_eq($sformatf("%s u%0d frame_done", name, k), 32'(fd_n[k] - b_fd[k]), 32'(exp_n));
      check_eq($sformatf("%s u%0d frame_shape", name, k), 32'(bad_fr[k] - b_bf[k]), 32'd0);
      check_eq($sformatf("%s u%0d ldac_width", name, k), 32'(bad_ldac[k] - b_bl[k]), 32'd0);
      exp_p = (k == 0) ? exp_n : (k == 2) ? 0 : (exp_n > 0 ? 1 : 0);
      check_eq($sformatf("%s u%0d ldac_pulses", name, k), 32'(pulses[k] - b_pul[k]), 32'(exp_p));
      if (k == 2) check_eq({name, " u2_ldac_high"}, 32'(ldac_hi[k] - b_hi[k]), 32'd0);
      check_eq($sformatf("%s u%0d wr_err", name, k), 32'(err_n[k] - b_err[k]),
               32'(k == 3 ? exp_inv : 0));
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s u%0d sync_n", name, k), 32'(sync_a[k]), 32'd1);
      check_eq($sformatf("%s u%0d sclk", name, k), 32'(sclk_a[k]), 32'd1);
      check_eq($sformatf("%s u%0d dout", name, k), 32'(dout_a[k]), 32'd0);
      check_eq($sformatf("%s u%0d busy", name, k), 32'(busy_a[k]), 32'd0);
      check_eq($sformatf("%s u%0d frame_done", name, k), 32'(fd_a[k]), 32'd0);
      check_eq($sformatf("%s u%0d wr_err", name, k), 32'(err_a[k]), 32'd0);
      check_eq($sformatf("%s u%0d ldac_n", name, k), 32'(ldac_a[k]), 32'(k == 2 ? 0 : 1));
      check_eq($sformatf("%s u%0d pending", name, k),
               32'(k == 3 ? {2'b00, pend6} : pend_a[k]), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = 3'd0; wr_val = 12'h000;
    repeat (4) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write ch3 = 0xABC.
    b_n = 1; b_ch[0] = 3; b_val[0] = 12'hABC; b_gap[0] = 0;
    run_burst("single");
    check_eq("single u1 0x3ABC", 32'(rx_fr[1][b_rx[1] % 256]), 32'h0000_3ABC);

    // Back-to-back ch0, ch5, ch2: served ch0, ch2, ch5.
    b_n = 3;
    b_ch[0] = 0; b_val[0] = 12'h010; b_gap[0] = 0;
    b_ch[1] = 5; b_val[1] = 12'h555; b_gap[1] = 0;
    b_ch[2] = 2; b_val[2] = 12'h2A2; b_gap[2] = 0;
    run_burst("burst3");
    check_eq("burst3 order0", 32'(rx_fr[1][(b_rx[1] + 0) % 256] >> 12), 32'd0);
    check_eq("burst3 order1", 32'(rx_fr[1][(b_rx[1] + 1) % 256] >> 12), 32'd2);
    check_eq("burst3 order2", 32'(rx_fr[1][(b_rx[1] + 2) % 256] >> 12), 32'd5);

    // ch1 written twice during a ch0 frame: one ch1 frame carrying the later value.
    b_n = 3;
    b_ch[0] = 0; b_val[0] = 12'h0F0; b_gap[0] = 40;
    b_ch[1] = 1; b_val[1] = 12'h111; b_gap[1] = 40;
    b_ch[2] = 1; b_val[2] = 12'h222; b_gap[2] = 0;
    run_burst("rewrite");
    check_eq("rewrite ch1 latest", 32'(rx_fr[1][(b_rx[1] + 1) % 256]), 32'h0000_1222);

    // Channel 7 is out of range for the 6-channel instance only.
    b_n = 1; b_ch[0] = 7; b_val[0] = 12'h5A5; b_gap[0] = 0;
    run_burst("badch");

    // Random bursts, all writes landing inside the first frame.
    for (int r = 0; r < 8; r++) begin
      b_n = int'($urandom_range(1, 6));
      for (int i = 0; i < b_n; i++) begin
        b_ch[i]  = int'($urandom_range(0, 7));
        b_val[i] = 12'($urandom_range(0, 4095));
        b_gap[i] = int'($urandom_range(0, 15));
      end
      run_burst($sformatf("rand%0d", r));
    end

    // Reset in the middle of a frame (around SHIFT bit 7).
    b_n = 2;
    b_ch[0] = 4; b_val[0] = 12'h0F0; b_ch[1] = 6; b_val[1] = 12'h777;
    for (int i = 0; i < b_n; i++) begin
      wr_en = 1'b1; wr_ch = 3'(b_ch[i]); wr_val = b_val[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    cyc = 0;
    while (nb[1] < 7 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midreset reached_bit7", 32'(nb[1] >= 7), 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snapshot();
    repeat (1000) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("midreset u%0d no_frames", k), 32'(rx_n[k] - b_rx[k]), 32'd0);
      check_eq($sformatf("midreset u%0d sync_quiet", k), 32'(sync_lo[k] - b_lo[k]), 32'd0);
      check_eq($sformatf("midreset u%0d busy", k), 32'(busy_a[k]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
